// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a single-entry receive buffer.
//
// The asynchronous rx line passes through a two-flop synchroniser. A low level
// starts a frame, and the start bit is re-checked at mid-bit. Data bits are then
// sampled LSB first at mid-bit using the same integer baud divider as the
// transmitter. A good stop bit loads the byte into the buffer. A bad stop bit
// pulses frame_err, and the receiver then waits for the line to return high.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   rx        asynchronous serial input, idles high
//   rd_en     read strobe, consumes the buffered byte
//   rx_data   last good byte received (not cleared by a read)
//   rx_valid  buffer holds an unread byte
//   frame_err one-cycle pulse on a bad stop bit
//   overrun   sticky: an unread byte was overwritten (cleared by a read)
//   rx_busy   receiver FSM is not idle (registered)
module uart_rx #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned BAUD_CNT_MAX = (CLK_FREQ / BAUD) - 1;
  localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
  localparam int unsigned CW = (BAUD_CNT_MAX < 1) ? 1 : $clog2(BAUD_CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CNT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] baud_cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          load;
  logic          ferr;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt + CW'(1);
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    load      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (baud_cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end else begin
            // Start bit gone by mid-bit: a glitch, drop it silently.
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_cnt == CNT_MAX) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == CNT_MAX) begin
          cnt_nxt = '0;
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = BRK;
          end
        end
      end
      BRK: begin
        // Held-low line after a bad stop bit must not look like a new start.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_busy   <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_busy   <= (state_nxt != IDLE);
      baud_cnt  <= cnt_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      frame_err <= ferr;
      if (rd_en && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      // Load wins over a same-cycle read for rx_valid; the read still
      // clears overrun because it suppresses the overrun set.
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_en) overrun <= 1'b1;
      end
    end
  end

endmodule
